// File: rtl/shift_normalizer_pkg.sv
// Shared encodings and sizes for the shift normalizer slice.
package shift_normalizer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic OP_LOGICAL = 1'b1;
    localparam logic OP_ARITH   = 1'b0;

    localparam int MAX_SHIFT = 3;
    localparam int DATA_W    = 4;
    localparam int K_W       = $clog2(MAX_SHIFT + 1);

endpackage

// File: rtl/shift_normalizer_norm_detect.sv
// Combinational terminate detector for one normalization step.
module norm_detect
    import shift_normalizer_pkg::*;
(
    input  logic [DATA_W-1:0] w,
    input  logic              op_type,
    input  logic [K_W-1:0]    k,
    output logic              stop
);

    logic msb_ok;

    always_comb begin
        // Arithmetic mode is normalized once the sign bit differs from the next bit.
        if (op_type == OP_LOGICAL) msb_ok = w[DATA_W-1];
        else                       msb_ok = w[DATA_W-1] ^ w[DATA_W-2];
        stop = msb_ok || (w == '0) || (k == K_W'(MAX_SHIFT));
    end

endmodule

// File: rtl/shift_normalizer.sv
// Sequential left-shift normalizer with signed restore count; one bit per SHIFT cycle.
module shift_normalizer
    import shift_normalizer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] num,
    input  logic              op_type,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] norm,
    output logic [DATA_W-1:0] count,
    output logic              zero
);

    state_t            state, state_next;
    logic [DATA_W-1:0] w;
    logic [K_W-1:0]    k;
    logic              mode;
    logic              stop;

    norm_detect u_norm_detect (
        .w       (w),
        .op_type (mode),
        .k       (k),
        .stop    (stop)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE:  if (start) state_next = SHIFT;
            SHIFT: begin
                busy = 1'b1;
                if (stop) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w     <= '0;
            k     <= '0;
            mode  <= OP_ARITH;
            norm  <= '0;
            count <= '0;
            zero  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        w    <= num;
                        k    <= '0;
                        mode <= op_type;
                    end
                end
                SHIFT: begin
                    if (stop) begin
                        norm  <= w;
                        count <= '0 - {{(DATA_W-K_W){1'b0}}, k};
                        zero  <= (w == '0);
                    end else begin
                        w <= {w[DATA_W-2:0], 1'b0};
                        k <= k + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/shift_normalizer.md
SHIFT_NORMALIZER -- requirements
Module: shift_normalizer

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: start  input  1  request; sampled only in IDLE.
REQ-004 SHALL: num  input  4  operand, captured on the accepted start.
REQ-005 SHALL: op_type  input  1  1 = logical, 0 = arithmetic; captured with num.
REQ-006 SHALL: busy  output  1  high while in SHIFT.
REQ-007 SHALL: done  output  1  one-cycle completion pulse.
REQ-008 SHALL: norm  output  4  normalized value.
REQ-009 SHALL: count  output  4  two's-complement restore count; negative = right shift by |count|.
REQ-010 SHALL: zero  output  1  high when the captured num = 0000.

Function
REQ-011 SHALL: FSM states are IDLE, SHIFT and DONE.
REQ-012 SHALL: IDLE with start=1 -> SHIFT.
- Load the work register with num, k = 0, and latch op_type.
REQ-013 SHALL: terminate condition, evaluated each SHIFT cycle on the work register w:
- Logical: w[3] = 1.
- Arithmetic: w[3] != w[2].
- Either mode: w = 0000, or k = 3.
REQ-014 SHALL: SHIFT with terminate true -> DONE.
- Register norm = w, count = -k (4-bit two's complement), zero = (w == 0000).
REQ-015 SHALL: SHIFT with terminate false -> stay in SHIFT.
- w <= w << 1, zero fill; k <= k + 1.
REQ-016 SHALL: DONE -> IDLE unconditionally; done = 1 only in DONE.
REQ-017 SHALL: latency from start edge to done edge is k + 2 edges, where k is in 0..3.
- done is high for exactly one cycle.
REQ-018 SHALL: start is ignored in SHIFT and DONE; no queuing.
REQ-019 SHALL: norm, count and zero hold their values from DONE until the next DONE or reset.
REQ-020 SHALL: feeding norm and count back into the existing signed-count shifter with the same op_type restores num exactly.
- Logical: norm >> k.
- Arithmetic: norm >>> k.
REQ-021 SHALL: arithmetic 1111 saturates at k = 3, giving norm = 1000 and count = 1101.
REQ-022 SHALL: num = 0000 terminates at k = 0 in either mode, giving count = 0000 and zero = 1.

Reset
REQ-023 SHALL: rst = 1 forces state = IDLE, busy = 0, done = 0, norm = 0000, count = 0000, zero = 0, k = 0.
REQ-024 SHALL: reset asserted in SHIFT or DONE aborts the operation.
- No done pulse is produced.
- Outputs take their reset values.
REQ-025 SHALL: start sampled in the same cycle as rst = 1 is discarded.

Structure
REQ-026 SHALL: the shared package holds:
- State encodings IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2.
- OP_LOGICAL = 1'b1, OP_ARITH = 1'b0.
- MAX_SHIFT = 3 and DATA_W = 4.
REQ-027 SHALL: the terminate condition of REQ-013 is one combinational sub-module, norm_detect.
- Inputs: w, op_type, k.
- Output: stop.
REQ-028 SHALL: the FSM, work register, k counter and output registers live in shift_normalizer.
- No combinational path from num or start to any output.

Verification
REQ-029 SHALL: logical, num = 0011 -> norm = 1100, count = 1110, zero = 0, done 4 edges after start.
REQ-030 SHALL: arithmetic, num = 0001 -> norm = 0100, count = 1110.
- Also check that 0100 >>> 2 = 0001.
REQ-031 SHALL: arithmetic, num = 1111 -> norm = 1000, count = 1101, done 5 edges after start.
REQ-032 SHALL: logical, num = 0000 -> norm = 0000, count = 0000, zero = 1, done 2 edges after start.
- Same for logical num = 1000: count = 0000, zero = 0.
REQ-033 SHALL: logical, num = 0001 with rst pulsed on the 2nd SHIFT cycle -> no done, all outputs 0 the cycle after, state IDLE.
REQ-034 SHALL: start re-asserted with num = 0110 while busy -> ignored; the first result completes unchanged.
- Then a random sweep of all 16 num values x 2 modes must pass the round-trip check of REQ-020.
